// File: rtl/icu_wide.sv
// One-bit-style industrial control unit widened to WIDTH-bit data, with a
// return stack for JMP/RTN and skip-on-zero sequencing.
module icu_wide #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        instruction,
    input  logic [ADDR_W-1:0] operand,
    output logic [ADDR_W-1:0] pc,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              write,
    output logic [WIDTH-1:0]  rr_out,
    output logic              flag_o,
    output logic              flag_f,
    output logic              stack_err
);
    typedef enum logic [3:0] {
        NOPO = 4'h0, LD   = 4'h1, LDC  = 4'h2, AND  = 4'h3,
        ANDC = 4'h4, OR   = 4'h5, ORC  = 4'h6, XNOR = 4'h7,
        STO  = 4'h8, STOC = 4'h9, IEN  = 4'hA, OEN  = 4'hB,
        JMP  = 4'hC, RTN  = 4'hD, SKZ  = 4'hE, NOPF = 4'hF
    } instruction_t;

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0]  rr_reg, rr_next;
    logic [WIDTH-1:0]  dout_reg, dout_next;
    logic              ien_reg, ien_next;
    logic              oen_reg, oen_next;
    logic              skip_reg, skip_next;
    logic              err_reg, err_next;
    logic [SP_W-1:0]   sp_reg, sp_next;
    logic [ADDR_W-1:0] stack_reg [DEPTH];

    instruction_t      op;
    logic              active;
    logic              is_store;
    logic              push;
    logic [WIDTH-1:0]  dm;
    logic [WIDTH-1:0]  store_val;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stack_top;

    assign op        = instruction_t'(instruction);
    assign active    = rst_n & ~skip_reg;
    assign dm        = ien_reg ? data_in : '0;
    assign pc_inc    = pc_reg + ADDR_W'(1);
    assign is_store  = (op == STO) || (op == STOC);
    assign store_val = (op == STOC) ? ~rr_reg : rr_reg;

    assign write     = active & oen_reg & is_store;
    assign data_out  = write ? store_val : dout_reg;
    assign flag_o    = active & (op == NOPO);
    assign flag_f    = active & (op == NOPF);
    assign pc        = pc_reg;
    assign rr_out    = rr_reg;
    assign stack_err = err_reg;

    // sp_reg counts occupied entries, so the top lives at index sp_reg-1
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_reg == SP_W'(i + 1))
                stack_top = stack_reg[i];
        end
    end

    always_comb begin
        rr_next   = rr_reg;
        dout_next = dout_reg;
        ien_next  = ien_reg;
        oen_next  = oen_reg;
        skip_next = 1'b0;
        err_next  = err_reg;
        sp_next   = sp_reg;
        pc_next   = pc_inc;
        push      = 1'b0;
        if (!skip_reg) begin
            case (op)
                LD:   rr_next = dm;
                LDC:  rr_next = ~dm;
                AND:  rr_next = rr_reg & dm;
                ANDC: rr_next = rr_reg & ~dm;
                OR:   rr_next = rr_reg | dm;
                ORC:  rr_next = rr_reg | ~dm;
                XNOR: rr_next = rr_reg ^ ~dm;
                STO, STOC: begin
                    if (oen_reg)
                        dout_next = store_val;
                end
                IEN:  ien_next = data_in[0];
                OEN:  oen_next = dm[0];
                JMP: begin
                    pc_next = operand;
                    if (sp_reg == SP_FULL) begin
                        err_next = 1'b1;
                    end else begin
                        push    = 1'b1;
                        sp_next = sp_reg + SP_W'(1);
                    end
                end
                RTN: begin
                    if (sp_reg == '0) begin
                        err_next = 1'b1;
                    end else begin
                        pc_next = stack_top;
                        sp_next = sp_reg - SP_W'(1);
                    end
                end
                SKZ:  skip_next = (rr_reg == '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg   <= '0;
            rr_reg   <= '0;
            dout_reg <= '0;
            ien_reg  <= 1'b0;
            oen_reg  <= 1'b0;
            skip_reg <= 1'b0;
            err_reg  <= 1'b0;
            sp_reg   <= '0;
        end else begin
            pc_reg   <= pc_next;
            rr_reg   <= rr_next;
            dout_reg <= dout_next;
            ien_reg  <= ien_next;
            oen_reg  <= oen_next;
            skip_reg <= skip_next;
            err_reg  <= err_next;
            sp_reg   <= sp_next;
        end
    end

    // Entry contents need no reset: sp_reg alone decides what is valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst_n && push && sp_reg == SP_W'(i))
                stack_reg[i] <= pc_inc;
        end
    end
endmodule
